// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the operand-forwarding / load-use hazard unit.
// Holds default widths and the MEM-over-WB select priority helper.
package fwd_hazard_unit_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 32;

  typedef struct packed {
    logic mem;
    logic wb;
  } fwd_sel_t;

  // MEM holds the younger producer, so it masks an older WB match.
  function automatic fwd_sel_t fwd_select(input logic hit_m, input logic hit_w);
    fwd_sel_t sel;
    sel.mem = hit_m;
    sel.wb  = hit_w & ~hit_m;
    return sel;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Single register-dependency comparator: a live stage writing a non-zero rd
// equal to the consumer's source register produces a hit.
module fwd_hazard_unit_match
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              i_valid,
  input  logic              i_regwrite,
  input  logic [REG_AW-1:0] i_rd,
  input  logic [REG_AW-1:0] i_rs,
  output logic              o_hit
);

  assign o_hit = i_valid & i_regwrite & (i_rd != '0) & (i_rd == i_rs);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select and load-use stall generator for the sail-core pipeline.
// Optional build macro: FWD_STALL_CNT_EN adds the stall_count port and counter.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
`ifdef FWD_STALL_CNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  output logic              stall,
  output logic              MEM_fwd1_reg,
  output logic              MEM_fwd2_reg,
  output logic              WB_fwd1_reg,
  output logic              WB_fwd2_reg
`ifdef FWD_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_count
`endif
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } ex_stage_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } mem_stage_t;

  // The instruction leaving MEM needs no tracking: WB write-through is the register file's job.
  ex_stage_t  r_ex;
  mem_stage_t r_mem;

  logic w_hit_m1, w_hit_m2, w_hit_w1, w_hit_w2;
  logic w_lu1, w_lu2;
  logic w_stall;
  fwd_sel_t w_sel1, w_sel2;

  fwd_hazard_unit_match #(.REG_AW(REG_AW)) u_match_m1 (
    .i_valid(r_ex.valid), .i_regwrite(r_ex.regwrite), .i_rd(r_ex.rd), .i_rs(id_rs1), .o_hit(w_hit_m1));
  fwd_hazard_unit_match #(.REG_AW(REG_AW)) u_match_m2 (
    .i_valid(r_ex.valid), .i_regwrite(r_ex.regwrite), .i_rd(r_ex.rd), .i_rs(id_rs2), .o_hit(w_hit_m2));
  fwd_hazard_unit_match #(.REG_AW(REG_AW)) u_match_w1 (
    .i_valid(r_mem.valid), .i_regwrite(r_mem.regwrite), .i_rd(r_mem.rd), .i_rs(id_rs1), .o_hit(w_hit_w1));
  fwd_hazard_unit_match #(.REG_AW(REG_AW)) u_match_w2 (
    .i_valid(r_mem.valid), .i_regwrite(r_mem.regwrite), .i_rd(r_mem.rd), .i_rs(id_rs2), .o_hit(w_hit_w2));

  // Load-use reuses the comparator with memread standing in for regwrite.
  fwd_hazard_unit_match #(.REG_AW(REG_AW)) u_match_lu1 (
    .i_valid(r_ex.valid), .i_regwrite(r_ex.memread), .i_rd(r_ex.rd), .i_rs(id_rs1), .o_hit(w_lu1));
  fwd_hazard_unit_match #(.REG_AW(REG_AW)) u_match_lu2 (
    .i_valid(r_ex.valid), .i_regwrite(r_ex.memread), .i_rd(r_ex.rd), .i_rs(id_rs2), .o_hit(w_lu2));

  // Stall request; a resolving branch kills the ID instruction so it never stalls.
  always_comb begin
    w_stall = 1'b0;
    if (flush) begin
      w_stall = 1'b0;
    end else begin
      w_stall = id_valid & (w_lu1 | w_lu2);
    end
  end

  assign stall = w_stall;

  // Select candidates for the ID instruction, resolved with MEM priority.
  always_comb begin
    w_sel1 = fwd_select(id_valid & w_hit_m1, id_valid & w_hit_w1);
    w_sel2 = fwd_select(id_valid & w_hit_m2, id_valid & w_hit_w2);
  end

  // Shadow pipeline and registered forwarding selects.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex         <= '0;
      r_mem        <= '0;
      MEM_fwd1_reg <= 1'b0;
      MEM_fwd2_reg <= 1'b0;
      WB_fwd1_reg  <= 1'b0;
      WB_fwd2_reg  <= 1'b0;
    end else begin
      r_mem <= '{valid: r_ex.valid, rd: r_ex.rd, regwrite: r_ex.regwrite};
      if (flush || w_stall) begin
        r_ex         <= '0;
        MEM_fwd1_reg <= 1'b0;
        MEM_fwd2_reg <= 1'b0;
        WB_fwd1_reg  <= 1'b0;
        WB_fwd2_reg  <= 1'b0;
      end else begin
        r_ex         <= '{valid: id_valid, rd: id_rd, regwrite: id_regwrite, memread: id_memread};
        MEM_fwd1_reg <= w_sel1.mem;
        MEM_fwd2_reg <= w_sel2.mem;
        WB_fwd1_reg  <= w_sel1.wb;
        WB_fwd2_reg  <= w_sel2.wb;
      end
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Free-running load-use stall counter, wraps naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall_count = r_stall_cnt;
`endif

endmodule
